avalon_mem_tester: RTL and testbench

Avalon-MM master that exercises an on-chip memory slave: writes a deterministic word pattern over a programmable address window, reads it back, and compares each word. A Nios II/host configures and starts it through a small Avalon-MM control slave and is notified by a level interrupt. It sits in the Qsys system as the initiator counterpart to the 32-bit single-port on-chip RAM.

---
 rtl/avalon_mem_tester_pkg.sv | 53 +++++
 rtl/avalon_mem_tester_if.sv | 40 ++++
 rtl/avalon_mem_tester_csr.sv | 139 +++++++++++++
 rtl/avalon_mem_tester.sv | 178 +++++++++++++++++
 tb/tb_avalon_mem_tester.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_mem_tester_pkg.sv
// Shared constants, state type and address/pattern helpers for the
// Avalon-MM memory tester.
package avalon_mem_tester_pkg;

    localparam int ADDR_W = 17;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Control slave register word indices
    localparam logic [2:0] REG_BASE    = 3'd0;
    localparam logic [2:0] REG_COUNT   = 3'd1;
    localparam logic [2:0] REG_SEED    = 3'd2;
    localparam logic [2:0] REG_CTRL    = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_ERRADDR = 3'd5;
    localparam logic [2:0] REG_ERRDATA = 3'd6;
    localparam logic [2:0] REG_ERRCNT  = 3'd7;

    // CTRL bit positions
    localparam int CTRL_START      = 0;
    localparam int CTRL_CHECK_ONLY = 1;
    localparam int CTRL_IRQ_EN     = 2;

    // STATUS bit positions
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERROR = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_FIN     = 3'd4
    } state_t;

    // Byte address of word idx, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        logic [ADDR_W+1:0] off;
        off = {{(ADDR_W-CNT_W){1'b0}}, idx, 2'b00};
        return base + off[ADDR_W-1:0];
    endfunction

    // Expected data word idx: seed + idx modulo 2^32.
    function automatic logic [31:0] pattern_word(input logic [31:0]      seed,
                                                 input logic [CNT_W-1:0] idx);
        return seed + {{(32-CNT_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/avalon_mem_tester_if.sv
// Bus bundle for the tester: Avalon-MM control slave, Avalon-MM master and irq.
// "master" is the tester's view, "slave" is the host/memory side.
interface avalon_mem_tester_if;
    import avalon_mem_tester_pkg::*;

    logic [2:0]        avs_address;
    logic              avs_chipselect;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;

    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_waitrequest;

    logic              irq;

    modport master (
        input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
        output avs_readdata,
        output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest,
        output irq
    );

    modport slave (
        output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
        input  avs_readdata,
        input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_readdatavalid, avm_waitrequest,
        input  irq
    );

endinterface

// File: rtl/avalon_mem_tester_csr.sv
// Control slave: register decode, configuration/status registers,
// mismatch capture and registered readdata mux.
module avalon_mem_tester_csr
    import avalon_mem_tester_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address_i,
    input  logic              chipselect_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [31:0]       writedata_i,
    output logic [31:0]       readdata_o,
    input  logic              busy_i,
    input  logic              fin_i,
    input  logic              mismatch_i,
    input  logic [ADDR_W-1:0] mm_addr_i,
    input  logic [31:0]       mm_data_i,
    output logic [ADDR_W-1:0] base_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [31:0]       seed_o,
    output logic              start_o,
    output logic              start_check_only_o,
    output logic              irq_o
);

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       seed_q;
    logic              check_only_q;
    logic              irq_en_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic [31:0]       err_data_q;
    logic [31:0]       err_count_q;
    logic [31:0]       readdata_q;

    logic wr_s;
    logic rd_s;
    logic start_s;
    logic clr_s;

    assign wr_s    = chipselect_i & write_i;
    assign rd_s    = chipselect_i & read_i;
    assign start_s = wr_s & (address_i == REG_CTRL) & writedata_i[CTRL_START] & ~busy_i;
    assign clr_s   = wr_s & (address_i == REG_STATUS) & writedata_i[STAT_DONE];

    assign base_o             = base_q;
    assign count_o            = count_q;
    assign seed_o             = seed_q;
    assign start_o            = start_s;
    assign start_check_only_o = writedata_i[CTRL_CHECK_ONLY];
    assign irq_o              = done_q & irq_en_q;
    assign readdata_o         = readdata_q;

    // Configuration registers; window/seed locked while a run is active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q       <= {ADDR_W{1'b0}};
            count_q      <= CNT_ZERO;
            seed_q       <= 32'h0;
            check_only_q <= 1'b0;
            irq_en_q     <= 1'b0;
        end else if (wr_s) begin
            if (!busy_i && address_i == REG_BASE) begin
                base_q <= {writedata_i[ADDR_W-1:2], 2'b00};
            end
            if (!busy_i && address_i == REG_COUNT) begin
                count_q <= writedata_i[CNT_W-1:0];
            end
            if (!busy_i && address_i == REG_SEED) begin
                seed_q <= writedata_i;
            end
            if (address_i == REG_CTRL) begin
                check_only_q <= writedata_i[CTRL_CHECK_ONLY];
                irq_en_q     <= writedata_i[CTRL_IRQ_EN];
            end
        end
    end

    // Status and error capture; later statements win, so set beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_addr_q  <= {ADDR_W{1'b0}};
            err_data_q  <= 32'h0;
            err_count_q <= 32'h0;
        end else begin
            if (start_s) begin
                done_q      <= 1'b0;
                error_q     <= 1'b0;
                err_addr_q  <= {ADDR_W{1'b0}};
                err_data_q  <= 32'h0;
                err_count_q <= 32'h0;
            end
            if (clr_s) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
            if (fin_i) begin
                done_q <= 1'b1;
            end
            if (mismatch_i) begin
                if (err_count_q == 32'h0) begin
                    error_q    <= 1'b1;
                    err_addr_q <= mm_addr_i;
                    err_data_q <= mm_data_i;
                end
                if (err_count_q != 32'hFFFF_FFFF) begin
                    err_count_q <= err_count_q + 32'd1;
                end
            end
        end
    end

    // Registered read mux, one cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= 32'h0;
        end else if (rd_s) begin
            case (address_i)
                REG_BASE:    readdata_q <= {{(32-ADDR_W){1'b0}}, base_q};
                REG_COUNT:   readdata_q <= {{(32-CNT_W){1'b0}}, count_q};
                REG_SEED:    readdata_q <= seed_q;
                REG_CTRL:    readdata_q <= {29'h0, irq_en_q, check_only_q, 1'b0};
                REG_STATUS:  readdata_q <= {29'h0, error_q, done_q, busy_i};
                REG_ERRADDR: readdata_q <= {{(32-ADDR_W){1'b0}}, err_addr_q};
                REG_ERRDATA: readdata_q <= err_data_q;
                REG_ERRCNT:  readdata_q <= err_count_q;
                default:     readdata_q <= 32'h0;
            endcase
        end else begin
            readdata_q <= 32'h0;
        end
    end

endmodule

// File: rtl/avalon_mem_tester.sv
// Avalon-MM memory tester top: write/read-back FSM and registered master port.
module avalon_mem_tester
    import avalon_mem_tester_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    avalon_mem_tester_if.master bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_w_q, base_w_d;
    logic [31:0]       seed_w_q, seed_w_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              read_q, read_d;

    logic              fin_s;
    logic              mismatch_s;
    logic              last_s;
    logic [CNT_W-1:0]  idx_next_s;
    logic              start_s;
    logic              start_chk_s;
    logic [ADDR_W-1:0] cfg_base_s;
    logic [CNT_W-1:0]  cfg_count_s;
    logic [31:0]       cfg_seed_s;
    logic [31:0]       avs_readdata_s;
    logic              irq_s;

    avalon_mem_tester_csr u_csr (
        .clk                (clk),
        .reset_n            (reset_n),
        .address_i          (bus.avs_address),
        .chipselect_i       (bus.avs_chipselect),
        .read_i             (bus.avs_read),
        .write_i            (bus.avs_write),
        .writedata_i        (bus.avs_writedata),
        .readdata_o         (avs_readdata_s),
        .busy_i             (state_q != ST_IDLE),
        .fin_i              (fin_s),
        .mismatch_i         (mismatch_s),
        .mm_addr_i          (addr_q),
        .mm_data_i          (bus.avm_readdata),
        .base_o             (cfg_base_s),
        .count_o            (cfg_count_s),
        .seed_o             (cfg_seed_s),
        .start_o            (start_s),
        .start_check_only_o (start_chk_s),
        .irq_o              (irq_s)
    );

    assign last_s     = (idx_q == (cnt_q - CNT_ONE));
    assign idx_next_s = idx_q + CNT_ONE;

    assign bus.avs_readdata   = avs_readdata_s;
    assign bus.irq            = irq_s;
    assign bus.avm_address    = addr_q;
    assign bus.avm_byteenable = 4'hF;
    assign bus.avm_read       = read_q;
    assign bus.avm_write      = write_q;
    assign bus.avm_writedata  = wdata_q;

    // Next-state and master-port next values; everything holds unless advanced.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        base_w_d   = base_w_q;
        seed_w_d   = seed_w_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        read_d     = read_q;
        fin_s      = 1'b0;
        mismatch_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    base_w_d = cfg_base_s;
                    cnt_d    = cfg_count_s;
                    seed_w_d = cfg_seed_s;
                    idx_d    = CNT_ZERO;
                    addr_d   = cfg_base_s;
                    if (cfg_count_s == CNT_ZERO) begin
                        state_d = ST_FIN;
                        fin_s   = 1'b1;
                    end else if (start_chk_s) begin
                        state_d = ST_RD_REQ;
                        read_d  = 1'b1;
                    end else begin
                        state_d = ST_WR;
                        write_d = 1'b1;
                        wdata_d = cfg_seed_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (!bus.avm_waitrequest) begin
                    if (last_s) begin
                        state_d = ST_RD_REQ;
                        idx_d   = CNT_ZERO;
                        write_d = 1'b0;
                        read_d  = 1'b1;
                        addr_d  = base_w_q;
                    end else begin
                        idx_d   = idx_next_s;
                        addr_d  = word_addr(base_w_q, idx_next_s);
                        wdata_d = pattern_word(seed_w_q, idx_next_s);
                    end
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RD_REQ: begin
                if (!bus.avm_waitrequest) begin
                    state_d = ST_RD_WAIT;
                    read_d  = 1'b0;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (bus.avm_readdatavalid) begin
                    mismatch_s = (bus.avm_readdata != pattern_word(seed_w_q, idx_q));
                    if (last_s) begin
                        state_d = ST_FIN;
                        fin_s   = 1'b1;
                    end else begin
                        state_d = ST_RD_REQ;
                        idx_d   = idx_next_s;
                        addr_d  = word_addr(base_w_q, idx_next_s);
                        read_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                write_d = 1'b0;
                read_d  = 1'b0;
            end
        endcase
    end

    // State, working copies and master-port registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= CNT_ZERO;
            cnt_q    <= CNT_ZERO;
            base_w_q <= {ADDR_W{1'b0}};
            seed_w_q <= 32'h0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= 32'h0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            base_w_q <= base_w_d;
            seed_w_q <= seed_w_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            read_q   <= read_d;
        end
    end

endmodule

// File: tb/tb_avalon_mem_tester.sv
// Directed bench for avalon_mem_tester with a zero/random-wait memory model.
module tb_avalon_mem_tester;
    import avalon_mem_tester_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    avalon_mem_tester_if bus();

    avalon_mem_tester dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [31:0] mem [0:32767];
    logic        rand_wait  = 1'b0;
    logic        corrupt_en = 1'b0;
    logic        pend_rd    = 1'b0;
    logic [31:0] pend_data  = 32'h0;
    int          hold_err   = 0;
    logic        prev_stall = 1'b0;
    logic        prev_wr, prev_rd;
    logic [16:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [16:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [16:0] rd_addr_log[$];

    // Memory responder: decides waitrequest, accepts transfers and returns
    // read data one cycle after acceptance; also watches stall stability.
    always @(negedge clk) begin
        bus.avm_readdatavalid = pend_rd;
        bus.avm_readdata      = pend_rd ? pend_data : 32'h0;
        pend_rd               = 1'b0;
        if (reset_n && prev_stall &&
            (bus.avm_write !== prev_wr || bus.avm_read !== prev_rd ||
             bus.avm_address !== prev_addr ||
             (prev_wr && bus.avm_writedata !== prev_wdata)))
            hold_err++;
        if (bus.avm_write === 1'b1 && bus.avm_read === 1'b1) hold_err++;
        bus.avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_stall = reset_n && (bus.avm_write || bus.avm_read) && bus.avm_waitrequest;
        prev_wr    = bus.avm_write;
        prev_rd    = bus.avm_read;
        prev_addr  = bus.avm_address;
        prev_wdata = bus.avm_writedata;
        if (reset_n && !bus.avm_waitrequest) begin
            if (bus.avm_write === 1'b1) begin
                mem[bus.avm_address[16:2]] = bus.avm_writedata;
                wr_addr_log.push_back(bus.avm_address);
                wr_data_log.push_back(bus.avm_writedata);
            end
            if (bus.avm_read === 1'b1) begin
                rd_addr_log.push_back(bus.avm_address);
                pend_rd   = 1'b1;
                pend_data = (corrupt_en && bus.avm_address == 17'h108) ? 32'hDEADBEEF
                                                                       : mem[bus.avm_address[16:2]];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_chipselect = 1'b1;
        bus.avs_write      = 1'b1;
        bus.avs_address    = a;
        bus.avs_writedata  = d;
        @(negedge clk);
        bus.avs_chipselect = 1'b0;
        bus.avs_write      = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avs_chipselect = 1'b1;
        bus.avs_read       = 1'b1;
        bus.avs_address    = a;
        @(negedge clk);
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        d = bus.avs_readdata;
    endtask

    // Programs the window, clears the logs and issues the CTRL write.
    task automatic start_run(input logic [31:0] base, input logic [31:0] count,
                             input logic [31:0] seed, input logic [31:0] ctrl);
        csr_write(REG_BASE, base);
        csr_write(REG_COUNT, count);
        csr_write(REG_SEED, seed);
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
        csr_write(REG_CTRL, ctrl);
    endtask

    // Waits for irq; cyc=1 on the first negedge after the START edge.
    task automatic wait_irq(input int budget, output int cyc);
        cyc = 1;
        while (bus.irq !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus.irq !== 1'b1) $display("FAIL wait_irq: irq=%b after %0d cycles, required 1", bus.irq, cyc);
        else passed++;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata, bus.irq, bus.avs_readdata} !== '0)
            $display("FAIL reset_outputs: wr=%b rd=%b addr=%h wd=%h irq=%b rdata=%h, required all 0",
                     bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata, bus.irq, bus.avs_readdata);
        else passed++;
        reset_n = 1'b1;
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h0) $display("FAIL reset_status: got %h, required 0", d); else passed++;
        csr_read(REG_COUNT, d);
        checks++;
        if (d !== 32'h0) $display("FAIL reset_count: got %h, required 0", d); else passed++;
    endtask

    task automatic check_run_logs(input string nm, input logic [16:0] base, input int n,
                                  input logic [31:0] seed, input bit with_wr);
        logic [16:0] ea;
        checks++;
        if (wr_addr_log.size() != (with_wr ? n : 0) || rd_addr_log.size() != n)
            $display("FAIL %s_log_size: writes=%0d reads=%0d, required %0d/%0d",
                     nm, wr_addr_log.size(), rd_addr_log.size(), with_wr ? n : 0, n);
        else passed++;
        for (int i = 0; i < n; i++) begin
            ea = base + 17'(i * 4);
            if (with_wr && i < wr_addr_log.size()) begin
                checks++;
                if (wr_addr_log[i] !== ea || wr_data_log[i] !== seed + 32'(i))
                    $display("FAIL %s_wr%0d: addr=%h data=%h, required %h/%h",
                             nm, i, wr_addr_log[i], wr_data_log[i], ea, seed + 32'(i));
                else passed++;
            end
            if (i < rd_addr_log.size()) begin
                checks++;
                if (rd_addr_log[i] !== ea)
                    $display("FAIL %s_rd%0d: addr=%h, required %h", nm, i, rd_addr_log[i], ea);
                else passed++;
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int cyc;
        rand_wait = 1'b0;
        start_run(32'h103, 32'd4, 32'hA5A50000, 32'h5);
        checks++;
        if (bus.avm_write !== 1'b1 || bus.avm_read !== 1'b0 || bus.avm_address !== 17'h100 ||
            bus.avm_writedata !== 32'hA5A50000 || bus.avm_byteenable !== 4'hF)
            $display("FAIL basic_start_latency: wr=%b rd=%b addr=%h wd=%h be=%h, required 1/0/100/a5a50000/f",
                     bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata, bus.avm_byteenable);
        else passed++;
        wait_irq(100, cyc);
        checks++;
        if (cyc !== 13) $display("FAIL basic_done_latency: got %0d cycles, required 13", cyc); else passed++;
        check_run_logs("basic", 17'h100, 4, 32'hA5A50000, 1'b1);
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) $display("FAIL basic_status: got %h, required 2", d); else passed++;
        csr_read(REG_ERRCNT, d);
        checks++;
        if (d !== 32'h0) $display("FAIL basic_errcount: got %h, required 0", d); else passed++;
        csr_read(REG_BASE, d);
        checks++;
        if (d !== 32'h100) $display("FAIL basic_base_align: got %h, required 100", d); else passed++;
    endtask

    task automatic test_random_stall();
        logic [31:0] d;
        int cyc;
        rand_wait = 1'b1;
        start_run(32'h100, 32'd4, 32'hA5A50000, 32'h5);
        wait_irq(400, cyc);
        rand_wait = 1'b0;
        check_run_logs("stall", 17'h100, 4, 32'hA5A50000, 1'b1);
        checks++;
        if (hold_err !== 0) $display("FAIL stall_hold: %0d stability violations, required 0", hold_err); else passed++;
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) $display("FAIL stall_status: got %h, required 2", d); else passed++;
    endtask

    task automatic test_mismatch();
        logic [31:0] d;
        int cyc;
        corrupt_en = 1'b1;
        start_run(32'h100, 32'd4, 32'hA5A50000, 32'h7);
        wait_irq(100, cyc);
        corrupt_en = 1'b0;
        check_run_logs("chk", 17'h100, 4, 32'hA5A50000, 1'b0);
        csr_read(REG_ERRADDR, d);
        checks++;
        if (d !== 32'h108) $display("FAIL chk_err_addr: got %h, required 108", d); else passed++;
        csr_read(REG_ERRDATA, d);
        checks++;
        if (d !== 32'hDEADBEEF) $display("FAIL chk_err_data: got %h, required deadbeef", d); else passed++;
        csr_read(REG_ERRCNT, d);
        checks++;
        if (d !== 32'h1) $display("FAIL chk_err_count: got %h, required 1", d); else passed++;
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h6 || bus.irq !== 1'b1)
            $display("FAIL chk_status_irq: status=%h irq=%b, required 6/1", d, bus.irq);
        else passed++;
        csr_write(REG_STATUS, 32'h2);
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h0 || bus.irq !== 1'b0)
            $display("FAIL chk_status_clear: status=%h irq=%b, required 0/0", d, bus.irq);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [16:0] exp_a [4];
        int cyc;
        exp_a[0] = 17'h1FFF8; exp_a[1] = 17'h1FFFC; exp_a[2] = 17'h00000; exp_a[3] = 17'h00004;
        start_run(32'h1FFF8, 32'd4, 32'h11110000, 32'h5);
        wait_irq(100, cyc);
        checks++;
        if (wr_addr_log.size() != 4 || rd_addr_log.size() != 4)
            $display("FAIL wrap_log_size: writes=%0d reads=%0d, required 4/4", wr_addr_log.size(), rd_addr_log.size());
        else passed++;
        for (int i = 0; i < 4 && i < wr_addr_log.size() && i < rd_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[i] !== exp_a[i] || rd_addr_log[i] !== exp_a[i])
                $display("FAIL wrap_addr%0d: wr=%h rd=%h, required %h", i, wr_addr_log[i], rd_addr_log[i], exp_a[i]);
            else passed++;
        end
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) $display("FAIL wrap_status: got %h, required 2", d); else passed++;
    endtask

    task automatic test_count_zero();
        logic [31:0] d;
        csr_write(REG_STATUS, 32'h2);
        checks++;
        if (bus.irq !== 1'b0) $display("FAIL zero_pre_irq: got %b, required 0", bus.irq); else passed++;
        start_run(32'h100, 32'd0, 32'h0, 32'h5);
        checks++;
        if (bus.irq !== 1'b1 || bus.avm_write !== 1'b0 || bus.avm_read !== 1'b0)
            $display("FAIL zero_done_next: irq=%b wr=%b rd=%b, required 1/0/0", bus.irq, bus.avm_write, bus.avm_read);
        else passed++;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_addr_log.size() != 0 || rd_addr_log.size() != 0)
            $display("FAIL zero_no_strobes: writes=%0d reads=%0d, required 0/0", wr_addr_log.size(), rd_addr_log.size());
        else passed++;
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) $display("FAIL zero_status: got %h, required 2", d); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int cyc;
        start_run(32'h100, 32'd4, 32'h5000, 32'h5);
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h1) $display("FAIL busy_status: got %h, required 1", d); else passed++;
        csr_write(REG_BASE, 32'h200);
        csr_write(REG_CTRL, 32'h5);
        wait_irq(100, cyc);
        repeat (6) @(negedge clk);
        check_run_logs("busy", 17'h100, 4, 32'h5000, 1'b1);
        csr_read(REG_BASE, d);
        checks++;
        if (d !== 32'h100) $display("FAIL busy_base_locked: got %h, required 100", d); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int cyc;
        start_run(32'h400, 32'd10, 32'h7700, 32'h5);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata, bus.irq, bus.avs_readdata} !== '0)
            $display("FAIL midreset_outputs: wr=%b rd=%b addr=%h wd=%h irq=%b, required all 0",
                     bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata, bus.irq);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h0) $display("FAIL midreset_status: got %h, required 0", d); else passed++;
        csr_read(REG_BASE, d);
        checks++;
        if (d !== 32'h0) $display("FAIL midreset_base: got %h, required 0", d); else passed++;
        start_run(32'h40, 32'd2, 32'h9, 32'h5);
        wait_irq(100, cyc);
        check_run_logs("rerun", 17'h40, 2, 32'h9, 1'b1);
        csr_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) $display("FAIL rerun_status: got %h, required 2", d); else passed++;
    endtask

    initial begin
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_address    = 3'd0;
        bus.avs_writedata  = 32'h0;
        test_reset();
        test_basic();
        test_random_stall();
        test_mismatch();
        test_wrap();
        test_count_zero();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
